// File: rtl/device_bus_arbiter.sv
// Round-robin initiator for the cluster device bus; one transaction in flight.
// Latency: bus fields and strobe 1 cycle after the request is sampled, ack/rdata 2 cycles after.
// Backpressure: cores hold core_req until their one-cycle ack; new grants only from IDLE (1 per 3 cycles).
//
// Ports:
//   i_clk, i_reset          rising-edge clock, synchronous active-high reset
//   i_core_req/_write       per-core request and direction (1 = store)
//   i_core_addr/_wdata      per-core packed address (10b each) and store data (16b each)
//   o_core_ack, o_core_rdata one-hot completion pulse and load data (gated to 0 outside COMPLETE)
//   o_device_*              registered shared-bus fields and strobes toward the responder
//   i_device_data_in        responder read data, valid the cycle after the read strobe
module device_bus_arbiter #(
  parameter int NUM_CORES = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_CORES-1:0]      i_core_req,
  input  logic [NUM_CORES-1:0]      i_core_write,
  input  logic [NUM_CORES*10-1:0]   i_core_addr,
  input  logic [NUM_CORES*16-1:0]   i_core_wdata,
  output logic [NUM_CORES-1:0]      o_core_ack,
  output logic [15:0]               o_core_rdata,
  output logic [3:0]                o_device_core_id,
  output logic                      o_device_write_en,
  output logic                      o_device_read_en,
  output logic [9:0]                o_device_addr,
  output logic [15:0]               o_device_data_out,
  input  logic [15:0]               i_device_data_in
);

  localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_COMPLETE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_grant_vld;
  logic [IW-1:0]        w_winner;
  logic                 w_found;
  int                   w_idx;
  logic [NUM_CORES-1:0] w_ack_onehot;

  logic [IW-1:0]        r_last_grant;
  logic [IW-1:0]        r_grant;
  logic [3:0]           r_dev_core_id;
  logic [9:0]           r_dev_addr;
  logic [15:0]          r_dev_data;
  logic                 r_dev_write_en;
  logic                 r_dev_read_en;
  logic [NUM_CORES-1:0] r_core_ack;

  // Round-robin search: start one past the last winner and wrap, so the
  // most recently served core is examined last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      w_idx = (int'(r_last_grant) + k) % NUM_CORES;
      if (!w_found && i_core_req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = IW'(w_idx);
      end
    end
  end

  always_comb begin
    w_ack_onehot = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_ack_onehot[i] = (int'(r_grant) == i);
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    w_grant_vld  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|i_core_req) begin
          w_grant_vld  = 1'b1;
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE:    w_next_state = S_COMPLETE;
      S_COMPLETE: w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Grant, bus fields, strobes and ack. Strobes and ack default low every
  // cycle so each is a single-cycle pulse; bus fields hold until the next grant.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_grant   <= IW'(NUM_CORES - 1);
      r_grant        <= '0;
      r_dev_core_id  <= '0;
      r_dev_addr     <= '0;
      r_dev_data     <= '0;
      r_dev_write_en <= 1'b0;
      r_dev_read_en  <= 1'b0;
      r_core_ack     <= '0;
    end else begin
      r_dev_write_en <= 1'b0;
      r_dev_read_en  <= 1'b0;
      r_core_ack     <= '0;
      if (w_grant_vld) begin
        r_grant        <= w_winner;
        r_last_grant   <= w_winner;
        r_dev_core_id  <= 4'(w_winner);
        r_dev_addr     <= i_core_addr[int'(w_winner)*10 +: 10];
        r_dev_data     <= i_core_wdata[int'(w_winner)*16 +: 16];
        r_dev_write_en <= i_core_write[w_winner];
        r_dev_read_en  <= !i_core_write[w_winner];
      end
      if (r_state == S_ISSUE) begin
        r_core_ack <= w_ack_onehot;
      end
    end
  end

  assign o_core_ack        = r_core_ack;
  assign o_device_core_id  = r_dev_core_id;
  assign o_device_write_en = r_dev_write_en;
  assign o_device_read_en  = r_dev_read_en;
  assign o_device_addr     = r_dev_addr;
  assign o_device_data_out = r_dev_data;

  // Responder data already arrives registered, so it is passed straight
  // through during COMPLETE and forced to zero otherwise.
  assign o_core_rdata = (r_state == S_COMPLETE) ? i_device_data_in : 16'h0000;

endmodule

// File: tb/tb_device_bus_arbiter.sv
module tb_device_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  core_req;
  logic [3:0]  core_write;
  logic [39:0] core_addr;
  logic [63:0] core_wdata;
  logic [3:0]  core_ack;
  logic [15:0] core_rdata;
  logic [3:0]  device_core_id;
  logic        device_write_en;
  logic        device_read_en;
  logic [9:0]  device_addr;
  logic [15:0] device_data_out;
  logic [15:0] device_data_in;

  int n_cmp;
  int n_err;

  device_bus_arbiter #(.NUM_CORES(4)) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_core_req        (core_req),
    .i_core_write      (core_write),
    .i_core_addr       (core_addr),
    .i_core_wdata      (core_wdata),
    .o_core_ack        (core_ack),
    .o_core_rdata      (core_rdata),
    .o_device_core_id  (device_core_id),
    .o_device_write_en (device_write_en),
    .o_device_read_en  (device_read_en),
    .o_device_addr     (device_addr),
    .o_device_data_out (device_data_out),
    .i_device_data_in  (device_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_core(input int c, input logic w, input logic [9:0] a, input logic [15:0] d);
    core_write[c]         = w;
    core_addr[c*10 +: 10] = a;
    core_wdata[c*16 +: 16] = d;
  endtask

  logic [3:0] exp_id;

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    reset          = 1'b1;
    core_req       = '0;
    core_write     = '0;
    core_addr      = '0;
    core_wdata     = '0;
    device_data_in = 16'hbeef;

    // Reset state; rdata must stay gated even with responder data present
    step();
    step();
    chk("rst_ack",   32'(core_ack), 32'h0);
    chk("rst_wr",    32'(device_write_en), 32'h0);
    chk("rst_rd",    32'(device_read_en), 32'h0);
    chk("rst_id",    32'(device_core_id), 32'h0);
    chk("rst_addr",  32'(device_addr), 32'h0);
    chk("rst_data",  32'(device_data_out), 32'h0);
    chk("rst_rdata", 32'(core_rdata), 32'h0);
    reset = 1'b0;

    // Single store from core 1
    set_core(1, 1'b1, 10'h3ff, 16'h1234);
    core_req = 4'b0010;
    step();
    chk("st_id",   32'(device_core_id), 32'h1);
    chk("st_wr",   32'(device_write_en), 32'h1);
    chk("st_rd",   32'(device_read_en), 32'h0);
    chk("st_addr", 32'(device_addr), 32'h3ff);
    chk("st_data", 32'(device_data_out), 32'h1234);
    chk("st_ack0", 32'(core_ack), 32'h0);
    step();
    chk("st_ack",  32'(core_ack), 32'b0010);
    chk("st_wr_off", 32'(device_write_en), 32'h0);
    core_req = 4'b0000;
    step();
    chk("st_ack_end", 32'(core_ack), 32'h0);
    chk("st_hold_addr", 32'(device_addr), 32'h3ff);
    chk("st_hold_id", 32'(device_core_id), 32'h1);

    // Single load from core 2
    device_data_in = 16'h0001;
    set_core(2, 1'b0, 10'h3fe, 16'h0000);
    core_req = 4'b0100;
    step();
    chk("ld_rd",   32'(device_read_en), 32'h1);
    chk("ld_wr",   32'(device_write_en), 32'h0);
    chk("ld_id",   32'(device_core_id), 32'h2);
    chk("ld_addr", 32'(device_addr), 32'h3fe);
    chk("ld_rdata_early", 32'(core_rdata), 32'h0);
    step();
    chk("ld_ack",   32'(core_ack), 32'b0100);
    chk("ld_rdata", 32'(core_rdata), 32'h0001);
    chk("ld_rd_off", 32'(device_read_en), 32'h0);
    core_req = 4'b0000;
    step();
    chk("ld_rdata_gate", 32'(core_rdata), 32'h0);

    // Field latching: core 0 address changes after the grant cycle
    set_core(0, 1'b0, 10'h010, 16'h0000);
    core_req = 4'b0001;
    step();
    chk("lat_id",   32'(device_core_id), 32'h0);
    chk("lat_addr", 32'(device_addr), 32'h010);
    set_core(0, 1'b0, 10'h020, 16'h0000);
    step();
    chk("lat_addr_hold", 32'(device_addr), 32'h010);
    chk("lat_ack", 32'(core_ack), 32'b0001);
    core_req = 4'b0000;
    step();

    // Reset asserted during ISSUE of a core-3 store
    set_core(3, 1'b1, 10'h155, 16'haaaa);
    core_req = 4'b1000;
    step();
    chk("rm_issue_id", 32'(device_core_id), 32'h3);
    chk("rm_issue_wr", 32'(device_write_en), 32'h1);
    reset    = 1'b1;
    core_req = 4'b1111;
    step();
    chk("rm_wr",  32'(device_write_en), 32'h0);
    chk("rm_rd",  32'(device_read_en), 32'h0);
    chk("rm_ack", 32'(core_ack), 32'h0);
    chk("rm_rdata", 32'(core_rdata), 32'h0);
    reset = 1'b0;

    // All four cores request continuously: grants 0,1,2,3,0,1 three cycles apart
    set_core(0, 1'b1, 10'h100, 16'h1000);
    set_core(1, 1'b0, 10'h101, 16'h1001);
    set_core(2, 1'b1, 10'h102, 16'h1002);
    set_core(3, 1'b0, 10'h103, 16'h1003);
    device_data_in = 16'h5a5a;
    for (int g = 0; g < 6; g++) begin
      exp_id = 4'(g % 4);
      step();
      chk($sformatf("rr%0d_id", g), 32'(device_core_id), 32'(exp_id));
      chk($sformatf("rr%0d_wr", g), 32'(device_write_en), 32'(core_write[exp_id]));
      chk($sformatf("rr%0d_rd", g), 32'(device_read_en), 32'(!core_write[exp_id]));
      chk($sformatf("rr%0d_addr", g), 32'(device_addr), 32'h100 + 32'(exp_id));
      step();
      chk($sformatf("rr%0d_ack", g), 32'(core_ack), 32'h1 << exp_id);
      chk($sformatf("rr%0d_rdata", g), 32'(core_rdata), 32'h5a5a);
      step();
      chk($sformatf("rr%0d_idle", g), 32'({core_ack, device_write_en, device_read_en}), 32'h0);
    end

    // Fairness: core 3 re-requests continuously, core 0 raises a single request
    core_req = 4'b1000;
    step();
    chk("fair_g1", 32'(device_core_id), 32'h3);
    core_req = 4'b1001;
    step();
    chk("fair_ack3", 32'(core_ack), 32'b1000);
    step();
    step();
    chk("fair_g2", 32'(device_core_id), 32'h0);
    step();
    chk("fair_ack0", 32'(core_ack), 32'b0001);
    core_req = 4'b1000;
    step();
    step();
    chk("fair_g3", 32'(device_core_id), 32'h3);
    core_req = 4'b0000;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
